// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - opcode, state and datapath-select encodings for the multicycle controller
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGEZ  = 6'b100111;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BALZ  = 6'b011010;
  localparam logic [5:0] OP_JSPAL = 6'b010011;

  typedef enum logic [4:0] {
    S_IDLE = 5'd0, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_REXEC, S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JSPRD, S_JSPWR, S_TRAP
  } state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_XOR} aluop_t;
  typedef enum logic [1:0] {SRCB_B, SRCB_4, SRCB_IMM, SRCB_IMMSL2} alusrcb_t;
  typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP, PC_MDR} pcsrc_t;

  typedef struct packed {
    logic r, lw, sw, br, imm, jmp, jsp, bad;
  } opclass_t;

endpackage

// File: rtl/mc_opdec.sv
// rtl/mc_opdec.sv - opcode to one-hot instruction class; MC_CUSTOM_OPS_EN enables bgez/balz/jspal
module mc_opdec
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output opclass_t       cls
);

  // Upper opcode bits must be zero, so compare against zero-extended constants.
  always_comb begin
    cls = '0;
    case (opcode)
      OPW'(OP_R):     cls.r   = 1'b1;
      OPW'(OP_LW):    cls.lw  = 1'b1;
      OPW'(OP_SW):    cls.sw  = 1'b1;
      OPW'(OP_BEQ):   cls.br  = 1'b1;
      OPW'(OP_XORI):  cls.imm = 1'b1;
`ifdef MC_CUSTOM_OPS_EN
      OPW'(OP_BGEZ):  cls.br  = 1'b1;
      OPW'(OP_BALZ):  cls.jmp = 1'b1;
      OPW'(OP_JSPAL): cls.jsp = 1'b1;
`endif
      default:        cls.bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing the multicycle datapath
// MC_CUSTOM_OPS_EN: decode bgez, balz and jspal (otherwise they trap and branch_gez stays 0)
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 2,
  parameter int STW    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              mem_ready,
  output logic              pcwrite,
  output logic              pcwritecond,
  output logic              branch_gez,
  output logic              iord,
  output logic              memread,
  output logic              memwrite,
  output logic              irwrite,
  output logic              memtoreg,
  output logic              regdest,
  output logic              regwrite,
  output logic              ext,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic [ALUOPW-1:0] aluop,
  output logic [1:0]        pcsrc,
  output logic              illegal,
  output logic [STW-1:0]    state
);

  state_t   state_q, state_d;
  opclass_t cls;
  aluop_t   aluop_e;

  mc_opdec #(.OPW(OPW)) u_opdec (
    .opcode (opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  assign aluop = ALUOPW'(aluop_e);
  assign state = STW'(state_q);

  always_comb begin
    state_d     = state_q;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    branch_gez  = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdest     = 1'b0;
    regwrite    = 1'b0;
    ext         = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_B;
    aluop_e     = ALU_ADD;
    pcsrc       = PC_ALU;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_4;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      // Branch target is computed speculatively into ALUOut here.
      S_DECODE: begin
        alusrcb = SRCB_IMMSL2;
        case (1'b1)
          cls.r:          state_d = S_REXEC;
          cls.lw, cls.sw: state_d = S_MEMADR;
          cls.br:         state_d = S_BRANCH;
          cls.imm:        state_d = S_IEXEC;
`ifdef MC_CUSTOM_OPS_EN
          cls.jmp:        state_d = S_JUMP;
          cls.jsp:        state_d = S_JSPRD;
`else
          cls.jmp, cls.jsp: state_d = S_TRAP;
`endif
          cls.bad:        state_d = S_TRAP;
          default:        state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = cls.lw ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_REXEC: begin
        alusrca = 1'b1;
        aluop_e = ALU_FUNCT;
        state_d = S_RWB;
      end
      S_RWB: begin
        regdest  = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop_e = ALU_XOR;
        ext     = 1'b1;
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        ext      = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop_e     = ALU_SUB;
        pcwritecond = 1'b1;
        pcsrc       = PC_ALUOUT;
`ifdef MC_CUSTOM_OPS_EN
        branch_gez  = (opcode == OPW'(OP_BGEZ));
`endif
        state_d     = S_FETCH;
      end
`ifdef MC_CUSTOM_OPS_EN
      S_JUMP: begin
        pcwrite = 1'b1;
        pcsrc   = PC_JUMP;
        state_d = S_FETCH;
      end
      S_JSPRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_JSPWR;
      end
      // New PC comes from the word just read, loaded as the write completes.
      S_JSPWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        pcsrc    = PC_MDR;
        if (mem_ready) begin
          pcwrite = 1'b1;
          state_d = S_FETCH;
        end
      end
`endif
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_ready = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic pcwrite, pcwritecond, branch_gez, iord, memread, memwrite, irwrite;
  logic memtoreg, regdest, regwrite, ext, alusrca, illegal;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [4:0] state;

  multicycle_control #(.OPW(6), .ALUOPW(2), .STW(5)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .branch_gez(branch_gez),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdest(regdest), .regwrite(regwrite), .ext(ext),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] F_NONE = 12'h000, F_PCW = 12'h800, F_PCWC = 12'h400,
    F_BGEZ = 12'h200, F_IORD = 12'h100, F_MRD = 12'h080, F_MWR = 12'h040,
    F_IRW = 12'h020, F_M2R = 12'h010, F_RDST = 12'h008, F_RW = 12'h004,
    F_EXT = 12'h002, F_ASA = 12'h001;

  typedef struct {
    logic        mr;
    logic [23:0] exp;
  } step_t;

  step_t sb[$];
  int n_checks = 0;
  int n_fails  = 0;

  function automatic logic [23:0] ev(input state_t st, input logic [11:0] f,
                                     input logic [1:0] b, input logic [1:0] a,
                                     input logic [1:0] p, input logic il);
    return {5'(st), il, p, a, b, f};
  endfunction

  function automatic logic [23:0] act();
    return {state, illegal, pcsrc, aluop, alusrcb, pcwrite, pcwritecond, branch_gez,
            iord, memread, memwrite, irwrite, memtoreg, regdest, regwrite, ext, alusrca};
  endfunction

  task automatic push(input logic mr, input logic [23:0] e);
    sb.push_back('{mr, e});
  endtask

  task automatic push_fetch_decode(input int waits);
    for (int i = 0; i < waits; i++) push(1'b0, ev(S_FETCH, F_MRD, 2'b01, 2'b00, 2'b00, 1'b0));
    push(1'b1, ev(S_FETCH, F_MRD | F_IRW | F_PCW, 2'b01, 2'b00, 2'b00, 1'b0));
    push(1'b1, ev(S_DECODE, F_NONE, 2'b11, 2'b00, 2'b00, 1'b0));
  endtask

  task automatic test_reset();
    step_t s;
    @(negedge clk); #1;
    n_checks++;
    if (act() !== 24'h0) begin
      n_fails++; $display("FAIL reset_hold: got %h expected %h", act(), 24'h0);
    end
    reset = 1'b0;
    push(1'b1, ev(S_IDLE, F_NONE, 2'b00, 2'b00, 2'b00, 1'b0));
    push(1'b0, ev(S_FETCH, F_MRD, 2'b01, 2'b00, 2'b00, 1'b0));
    for (int i = 0; sb.size() > 0; i++) begin
      s = sb.pop_front(); mem_ready = s.mr; #1;
      n_checks++;
      if (act() !== s.exp) begin
        n_fails++; $display("FAIL reset_release step %0d: got %h expected %h", i, act(), s.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw();
    step_t s;
    opcode = OP_LW;
    push_fetch_decode(3);
    push(1'b1, ev(S_MEMADR, F_ASA, 2'b10, 2'b00, 2'b00, 1'b0));
    push(1'b0, ev(S_MEMRD, F_MRD | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0));
    push(1'b1, ev(S_MEMRD, F_MRD | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0));
    push(1'b1, ev(S_MEMWB, F_RW | F_M2R, 2'b00, 2'b00, 2'b00, 1'b0));
    for (int i = 0; sb.size() > 0; i++) begin
      s = sb.pop_front(); mem_ready = s.mr; #1;
      n_checks++;
      if (act() !== s.exp) begin
        n_fails++; $display("FAIL lw step %0d: got %h expected %h", i, act(), s.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    step_t s;
    opcode = OP_LW;
    push_fetch_decode(0);
    push(1'b0, ev(S_MEMADR, F_ASA, 2'b10, 2'b00, 2'b00, 1'b0));
    push(1'b0, ev(S_MEMRD, F_MRD | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0));
    for (int i = 0; sb.size() > 0; i++) begin
      s = sb.pop_front(); mem_ready = s.mr; #1;
      n_checks++;
      if (act() !== s.exp) begin
        n_fails++; $display("FAIL reset_mid step %0d: got %h expected %h", i, act(), s.exp);
      end
      if (sb.size() > 0) @(negedge clk);
    end
    reset = 1'b1; #1;
    n_checks++;
    if (act() !== 24'h0) begin
      n_fails++; $display("FAIL reset_mid_async: got %h expected %h", act(), 24'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    push(1'b1, ev(S_IDLE, F_NONE, 2'b00, 2'b00, 2'b00, 1'b0));
    push(1'b0, ev(S_FETCH, F_MRD, 2'b01, 2'b00, 2'b00, 1'b0));
    for (int i = 0; sb.size() > 0; i++) begin
      s = sb.pop_front(); mem_ready = s.mr; #1;
      n_checks++;
      if (act() !== s.exp) begin
        n_fails++; $display("FAIL reset_mid_release step %0d: got %h expected %h", i, act(), s.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    step_t s;
    opcode = OP_BEQ;
    push_fetch_decode(0);
    push(1'b1, ev(S_BRANCH, F_ASA | F_PCWC, 2'b00, 2'b01, 2'b01, 1'b0));
    for (int i = 0; sb.size() > 0; i++) begin
      s = sb.pop_front(); mem_ready = s.mr; #1;
      n_checks++;
      if (act() !== s.exp) begin
        n_fails++; $display("FAIL beq step %0d: got %h expected %h", i, act(), s.exp);
      end
      @(negedge clk);
    end
    opcode = OP_BGEZ;
    push_fetch_decode(1);
`ifdef MC_CUSTOM_OPS_EN
    push(1'b1, ev(S_BRANCH, F_ASA | F_PCWC | F_BGEZ, 2'b00, 2'b01, 2'b01, 1'b0));
`else
    push(1'b1, ev(S_TRAP, F_NONE, 2'b00, 2'b00, 2'b00, 1'b1));
`endif
    for (int i = 0; sb.size() > 0; i++) begin
      s = sb.pop_front(); mem_ready = s.mr; #1;
      n_checks++;
      if (act() !== s.exp) begin
        n_fails++; $display("FAIL bgez step %0d: got %h expected %h", i, act(), s.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_xori();
    step_t s;
    opcode = OP_XORI;
    push_fetch_decode(0);
    push(1'b1, ev(S_IEXEC, F_ASA | F_EXT, 2'b10, 2'b11, 2'b00, 1'b0));
    push(1'b1, ev(S_IWB, F_RW | F_EXT, 2'b00, 2'b00, 2'b00, 1'b0));
    for (int i = 0; sb.size() > 0; i++) begin
      s = sb.pop_front(); mem_ready = s.mr; #1;
      n_checks++;
      if (act() !== s.exp) begin
        n_fails++; $display("FAIL xori step %0d: got %h expected %h", i, act(), s.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw_rtype();
    step_t s;
    opcode = OP_SW;
    push_fetch_decode(0);
    push(1'b0, ev(S_MEMADR, F_ASA, 2'b10, 2'b00, 2'b00, 1'b0));
    push(1'b0, ev(S_MEMWR, F_MWR | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0));
    push(1'b1, ev(S_MEMWR, F_MWR | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0));
    for (int i = 0; sb.size() > 0; i++) begin
      s = sb.pop_front(); mem_ready = s.mr; #1;
      n_checks++;
      if (act() !== s.exp) begin
        n_fails++; $display("FAIL sw step %0d: got %h expected %h", i, act(), s.exp);
      end
      @(negedge clk);
    end
    opcode = OP_R;
    push_fetch_decode(0);
    push(1'b1, ev(S_REXEC, F_ASA, 2'b00, 2'b10, 2'b00, 1'b0));
    push(1'b1, ev(S_RWB, F_RDST | F_RW, 2'b00, 2'b00, 2'b00, 1'b0));
    for (int i = 0; sb.size() > 0; i++) begin
      s = sb.pop_front(); mem_ready = s.mr; #1;
      n_checks++;
      if (act() !== s.exp) begin
        n_fails++; $display("FAIL rtype step %0d: got %h expected %h", i, act(), s.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_trap();
    step_t s;
    opcode = 6'b111111;
    push_fetch_decode(0);
    push(1'b1, ev(S_TRAP, F_NONE, 2'b00, 2'b00, 2'b00, 1'b1));
    push(1'b0, ev(S_FETCH, F_MRD, 2'b01, 2'b00, 2'b00, 1'b0));
    for (int i = 0; sb.size() > 0; i++) begin
      s = sb.pop_front(); mem_ready = s.mr; #1;
      n_checks++;
      if (act() !== s.exp) begin
        n_fails++; $display("FAIL trap step %0d: got %h expected %h", i, act(), s.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_custom_ops();
    step_t s;
    opcode = OP_JSPAL;
    push_fetch_decode(0);
`ifdef MC_CUSTOM_OPS_EN
    push(1'b0, ev(S_JSPRD, F_MRD | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0));
    push(1'b1, ev(S_JSPRD, F_MRD | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0));
    push(1'b0, ev(S_JSPWR, F_MWR | F_IORD, 2'b00, 2'b00, 2'b11, 1'b0));
    push(1'b1, ev(S_JSPWR, F_MWR | F_IORD | F_PCW, 2'b00, 2'b00, 2'b11, 1'b0));
`else
    push(1'b1, ev(S_TRAP, F_NONE, 2'b00, 2'b00, 2'b00, 1'b1));
`endif
    opcode = OP_JSPAL;
    for (int i = 0; sb.size() > 0; i++) begin
      s = sb.pop_front(); mem_ready = s.mr; #1;
      n_checks++;
      if (act() !== s.exp) begin
        n_fails++; $display("FAIL jspal step %0d: got %h expected %h", i, act(), s.exp);
      end
      @(negedge clk);
    end
    opcode = OP_BALZ;
    push_fetch_decode(0);
`ifdef MC_CUSTOM_OPS_EN
    push(1'b1, ev(S_JUMP, F_PCW, 2'b00, 2'b00, 2'b10, 1'b0));
`else
    push(1'b1, ev(S_TRAP, F_NONE, 2'b00, 2'b00, 2'b00, 1'b1));
`endif
    push(1'b0, ev(S_FETCH, F_MRD, 2'b01, 2'b00, 2'b00, 1'b0));
    for (int i = 0; sb.size() > 0; i++) begin
      s = sb.pop_front(); mem_ready = s.mr; #1;
      n_checks++;
      if (act() !== s.exp) begin
        n_fails++; $display("FAIL balz step %0d: got %h expected %h", i, act(), s.exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_reset_mid();
    test_branch();
    test_xori();
    test_sw_rtype();
    test_trap();
    test_custom_ops();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
